// File: rtl/bcd_reverse_dabble.sv
// rtl/bcd_reverse_dabble.sv - four-digit BCD to 14-bit binary converter, reverse double dabble
// Operates one shift per cycle: 14 shift cycles then a one-cycle DONE pulse.
module bcd_reverse_dabble #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  Thousands_Data,
  input  logic [3:0]  Hundreds_Data,
  input  logic [3:0]  Tens_Data,
  input  logic [3:0]  Ones_Data,
  output logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic [13:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin_q, bin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [29:0] shifted;
  logic [29:0] dabbled;
  logic        digit_bad;

  // A nibble reading >=8 after the shift holds a tens-bit worth 5, not 8.
  always_comb begin
    shifted = {bcd_q, acc_q} >> 1;
    dabbled = shifted;
    for (int i = 0; i < 4; i++) begin
      if (shifted[14+4*i +: 4] >= 4'd8) begin
        dabbled[14+4*i +: 4] = shifted[14+4*i +: 4] - 4'd3;
      end
    end
  end

  assign digit_bad = (Thousands_Data > 4'd9) || (Hundreds_Data > 4'd9) ||
                     (Tens_Data > 4'd9) || (Ones_Data > 4'd9);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (digit_bad) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = SHIFT;
            bcd_d   = {Thousands_Data, Hundreds_Data, Tens_Data, Ones_Data};
            acc_d   = '0;
            cnt_d   = 4'd13;
            busy_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        bcd_d = dabbled[29:14];
        acc_d = dabbled[13:0];
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          bin_d   = dabbled[13:0];
          ovf_d   = ({18'd0, dabbled[13:0]} > LIMIT);
          err_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_reverse_dabble.sv
// tb/tb_bcd_reverse_dabble.sv - self-checking bench for bcd_reverse_dabble
// Reference: decimal digit arithmetic, binary-to-BCD by division for round trips.
module tb_bcd_reverse_dabble;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  th = 4'd0, hu = 4'd0, te = 4'd0, on = 4'd0;
  logic [13:0] bin;
  logic        busy, done, err, ovf;

  int errors = 0;
  int checks = 0;

  localparam int LIMIT = 1023;

  bcd_reverse_dabble dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Thousands_Data(th), .Hundreds_Data(hu), .Tens_Data(te), .Ones_Data(on),
    .bin(bin), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int dec_value(input int a, input int b, input int c, input int d);
    return a * 1000 + b * 100 + c * 10 + d;
  endfunction

  // Runs one request; lat is the cycle index (1 = cycle after sampling edge) where done is seen.
  task automatic convert(input logic [3:0] a, b, c, d,
                         output int lat, output int busy_n, output logic done_after);
    @(negedge clk);
    th = a; hu = b; te = c; on = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_n = 0; done_after = 1'bx;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bin, busy, done, err, ovf} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got bin=%0d busy=%b done=%b err=%b ovf=%b, want all 0",
               bin, busy, done, err, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    int lat, bn; logic da;
    convert(0, 0, 0, 0, lat, bn, da);
    checks++;
    if (lat !== 15 || bn !== 14 || da !== 1'b0) begin
      errors++;
      $display("FAIL zero_timing: got lat=%0d busy_cycles=%0d done_next=%b, want 15 14 0", lat, bn, da);
    end
    checks++;
    if (bin !== 14'd0 || ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: got bin=%0d ovf=%b err=%b, want 0 0 0", bin, ovf, err);
    end
  endtask

  task automatic test_limit;
    int lat, bn; logic da;
    convert(1, 0, 2, 3, lat, bn, da);
    checks++;
    if (bin !== 14'd1023 || ovf !== 1'b0 || err !== 1'b0 || lat !== 15) begin
      errors++;
      $display("FAIL limit_1023: got bin=%0d ovf=%b err=%b lat=%0d, want 1023 0 0 15", bin, ovf, err, lat);
    end
    convert(1, 0, 2, 4, lat, bn, da);
    checks++;
    if (bin !== 14'd1024 || ovf !== 1'b1 || err !== 1'b0 || lat !== 15) begin
      errors++;
      $display("FAIL limit_1024: got bin=%0d ovf=%b err=%b lat=%0d, want 1024 1 0 15", bin, ovf, err, lat);
    end
  endtask

  task automatic test_max_and_err;
    int lat, bn; logic da;
    convert(9, 9, 9, 9, lat, bn, da);
    checks++;
    if (bin !== 14'd9999 || ovf !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL max_9999: got bin=%0d ovf=%b err=%b, want 9999 1 0", bin, ovf, err);
    end
    convert(9, 9, 4'hA, 9, lat, bn, da);
    checks++;
    if (lat !== 1 || bn !== 0 || da !== 1'b0) begin
      errors++;
      $display("FAIL err_timing: got lat=%0d busy_cycles=%0d done_next=%b, want 1 0 0", lat, bn, da);
    end
    checks++;
    if (err !== 1'b1 || bin !== 14'd9999 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: got err=%b bin=%0d ovf=%b, want 1 9999 1", err, bin, ovf);
    end
    convert(0, 0, 1, 2, lat, bn, da);
    checks++;
    if (err !== 1'b0 || bin !== 14'd12 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%b bin=%0d ovf=%b, want 0 12 0", err, bin, ovf);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    th = 1; hu = 2; te = 3; on = 4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        lat = cyc;
        break;
      end
      if (cyc == 5) begin
        th = 9; hu = 8; te = 7; on = 6; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 15 || bin !== 14'd1234) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d bin=%0d, want 15 1234", lat, bin);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bn, seen; logic da;
    @(negedge clk);
    th = 5; hu = 5; te = 5; on = 5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bin, busy, done, err, ovf} !== 18'd0) begin
      errors++;
      $display("FAIL abort_outputs: got bin=%0d busy=%b done=%b err=%b ovf=%b, want all 0",
               bin, busy, done, err, ovf);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", seen);
    end
    convert(0, 4, 5, 6, lat, bn, da);
    checks++;
    if (bin !== 14'd456 || lat !== 15 || ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: got bin=%0d lat=%0d ovf=%b err=%b, want 456 15 0 0", bin, lat, ovf, err);
    end
  endtask

  task automatic test_back_to_back;
    int exp_v, cyc, last;
    logic [3:0] d [4];
    for (int j = 0; j < 4; j++) d[j] = 4'($urandom_range(0, 9));
    exp_v = dec_value(d[0], d[1], d[2], d[3]);
    @(negedge clk);
    th = d[0]; hu = d[1]; te = d[2]; on = d[3]; start = 1'b1;
    cyc = 0; last = 0;
    for (int k = 0; k < 5; k++) begin
      int got;
      got = 0;
      for (int w = 0; w < 40; w++) begin
        @(posedge clk); #1;
        cyc++;
        if (done) begin
          got = 1;
          break;
        end
      end
      checks++;
      if (!got || bin !== 14'(exp_v) || (k > 0 && cyc - last !== 16)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got done=%0d bin=%0d spacing=%0d, want 1 %0d 16",
                 k, got, bin, cyc - last, exp_v);
      end
      last = cyc;
      for (int j = 0; j < 4; j++) d[j] = 4'($urandom_range(0, 9));
      exp_v = dec_value(d[0], d[1], d[2], d[3]);
      th = d[0]; hu = d[1]; te = d[2]; on = d[3];
      if (k == 4) start = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat, bn, exp_bin, exp_lat;
    logic da, exp_ovf, exp_err;
    logic [3:0] d [4];
    exp_bin = int'(bin);
    exp_ovf = ovf;
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 15) == 0) d[j] = 4'($urandom_range(10, 15));
        else d[j] = 4'($urandom_range(0, 9));
      end
      if (d[0] > 9 || d[1] > 9 || d[2] > 9 || d[3] > 9) begin
        exp_err = 1'b1;
        exp_lat = 1;
      end else begin
        exp_err = 1'b0;
        exp_lat = 15;
        exp_bin = dec_value(d[0], d[1], d[2], d[3]);
        exp_ovf = (exp_bin > LIMIT);
      end
      convert(d[0], d[1], d[2], d[3], lat, bn, da);
      checks++;
      if (bin !== 14'(exp_bin) || ovf !== exp_ovf || err !== exp_err || lat !== exp_lat) begin
        errors++;
        $display("FAIL random[%0d] %0d%0d%0d%0d: got bin=%0d ovf=%b err=%b lat=%0d, want %0d %b %b %0d",
                 n, d[0], d[1], d[2], d[3], bin, ovf, err, lat, exp_bin, exp_ovf, exp_err, exp_lat);
      end
    end
  endtask

  task automatic test_roundtrip;
    int lat, bn; logic da;
    for (int v = 0; v <= 1023; v++) begin
      convert(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), lat, bn, da);
      checks++;
      if (bin !== 14'(v) || ovf !== 1'b0 || err !== 1'b0 || lat !== 15) begin
        errors++;
        $display("FAIL roundtrip[%0d]: got bin=%0d ovf=%b err=%b lat=%0d, want %0d 0 0 15",
                 v, bin, ovf, err, lat, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_limit();
    test_max_and_err();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_roundtrip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_reverse_dabble.md
BCD_REVERSE_DABBLE -- requirements
Module: bcd_reverse_dabble

Interface
REQ-001 The block SHALL expose parameter LIMIT, default 1023, meaning the largest result that does not set ovf (the 10-bit Hz range).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 clk  input  1  rising-edge system clock (100 MHz).
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request conversion; sampled only in IDLE.
REQ-006 Thousands_Data  input  4  BCD thousands digit.
REQ-007 Hundreds_Data  input  4  BCD hundreds digit.
REQ-008 Tens_Data  input  4  BCD tens digit.
REQ-009 Ones_Data  input  4  BCD ones digit.
REQ-010 bin  output  14  converted binary value, registered, held until the next completion.
REQ-011 busy  output  1  high while a conversion is in progress.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 err  output  1  last request had a digit >9; held until the next completion.
REQ-014 ovf  output  1  last valid result > LIMIT; held until the next completion.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, DONE; any other encoding SHALL go to IDLE.
REQ-016 IDLE with start=1: capture the four digits into a 16-bit BCD register, clear a 14-bit accumulator, load step counter = 13, set busy, go to SHIFT.
REQ-017 IDLE with start=1 and any digit >9: skip SHIFT, go directly to DONE with err=1, leave bin and ovf unchanged.
REQ-018 Each SHIFT cycle: shift the 30-bit {BCD, accumulator} right by one bit, then subtract 3 from every BCD nibble whose post-shift value is >=8.
REQ-019 SHIFT SHALL run exactly 14 cycles (counter 13 down to 0), then go to DONE.
REQ-020 On entry to DONE: load bin from the accumulator, set ovf = (result > LIMIT), clear err, clear busy, pulse done for exactly one cycle.
REQ-021 DONE SHALL return to IDLE after one cycle and SHALL ignore start.
REQ-022 Valid-conversion latency: done high in the 15th cycle after the edge that samples start; busy high for the 14 cycles before that.
REQ-023 Invalid-digit latency: done high in the cycle after the sampling edge; busy never asserts.
REQ-024 start while busy or in DONE SHALL be ignored; digit changes during SHIFT SHALL NOT affect the result.
REQ-025 start held high continuously SHALL begin a new conversion in the IDLE cycle following each DONE, giving one result every 16 cycles.
REQ-026 All arithmetic SHALL be unsigned; the maximum result 9999 SHALL fit in 14 bits with no truncation.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and bin=0, busy=0, done=0, err=0, ovf=0, with internal registers cleared.
REQ-028 Reset asserted mid-conversion SHALL abort with no done pulse; the first start after rst_n rises SHALL convert normally.

Verification
REQ-029 Digits 0,0,0,0 plus start pulse -> done in 15th cycle, bin=0, ovf=0, err=0.
REQ-030 Digits 1,0,2,3 -> bin=1023 (0x3FF), ovf=0; digits 1,0,2,4 -> bin=1024, ovf=1.
REQ-031 Digits 9,9,9,9 -> bin=9999 (0x270F), ovf=1; then Tens_Data=0xA with start -> done next cycle, err=1, bin still 9999.
REQ-032 start re-pulsed at cycle 5 of a conversion with different digits -> ignored; the original result completes at the same time.
REQ-033 rst_n low at cycle 7 of a conversion -> all outputs 0 immediately, no done pulse; next conversion of 0,4,5,6 -> bin=456.
REQ-034 Round-trip, all 0..1023: binary-to-BCD converter output fed to this block -> bin equals the original value, ovf=0, err=0 for every value.
